// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings used by the M/W pipeline stages.
package rv32i_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/half lane and sign/zero extends it.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*addr_i +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipeline.sv
// EX/MEM and MEM/WB pipeline registers: store formatting in M, load extend and
// result select in W, plus the retired-instruction counter.
module mem_wb_pipeline
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallM,
  input  logic             flushM,
  input  logic             validE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       funct3E,
  input  logic [4:0]       rdE,
  input  logic [XLEN-1:0]  alu_resultE,
  input  logic [XLEN-1:0]  write_dataE,
  input  logic [XLEN-1:0]  pc_plus4E,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             validM,
  output logic             RegWriteM,
  output logic [4:0]       rdM,
  output logic [XLEN-1:0]  alu_resultM,
  output logic [XLEN-1:0]  dmem_addr,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             validW,
  output logic             RegWriteW,
  output logic [4:0]       rdW,
  output logic [XLEN-1:0]  resultW,
  output logic [CNT_W-1:0] instret
);

  // EX/MEM state
  logic            valid_m_q, reg_write_m_q, mem_write_m_q;
  logic [1:0]      result_src_m_q;
  logic [2:0]      funct3_m_q;
  logic [4:0]      rd_m_q;
  logic [XLEN-1:0] alu_result_m_q, write_data_m_q, pc_plus4_m_q;

  // MEM/WB state
  logic             valid_w_q, reg_write_w_q;
  logic [1:0]       result_src_w_q;
  logic [2:0]       funct3_w_q;
  logic [4:0]       rd_w_q;
  logic [XLEN-1:0]  alu_result_w_q, pc_plus4_w_q, rdata_w_q;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0] load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m_q      <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      funct3_m_q     <= '0;
      rd_m_q         <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      pc_plus4_m_q   <= '0;
    end else if (flushM) begin
      valid_m_q     <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
    end else if (!stallM) begin
      valid_m_q      <= validE;
      reg_write_m_q  <= RegWriteE & validE;
      mem_write_m_q  <= MemWriteE & validE;
      result_src_m_q <= ResultSrcE;
      funct3_m_q     <= funct3E;
      rd_m_q         <= rdE;
      alu_result_m_q <= alu_resultE;
      write_data_m_q <= write_dataE;
      pc_plus4_m_q   <= pc_plus4E;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_w_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      funct3_w_q     <= '0;
      rd_w_q         <= '0;
      alu_result_w_q <= '0;
      pc_plus4_w_q   <= '0;
      rdata_w_q      <= '0;
    end else if (stallM) begin
      valid_w_q     <= 1'b0;
      reg_write_w_q <= 1'b0;
    end else begin
      valid_w_q      <= valid_m_q;
      reg_write_w_q  <= reg_write_m_q & valid_m_q;
      result_src_w_q <= result_src_m_q;
      funct3_w_q     <= funct3_m_q;
      rd_w_q         <= rd_m_q;
      alu_result_w_q <= alu_result_m_q;
      pc_plus4_w_q   <= pc_plus4_m_q;
      rdata_w_q      <= dmem_rdata;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (valid_w_q) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  // M-stage outputs and store lane formatting
  always_comb begin
    validM      = valid_m_q;
    RegWriteM   = reg_write_m_q & valid_m_q;
    rdM         = rd_m_q;
    alu_resultM = alu_result_m_q;
    dmem_addr   = alu_result_m_q;
    dmem_we     = mem_write_m_q & valid_m_q;
    dmem_be     = 4'b0000;
    dmem_wdata  = write_data_m_q;
    case (funct3_m_q[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << alu_result_m_q[1:0];
        dmem_wdata = {4{write_data_m_q[7:0]}};
      end
      2'b01: begin
        dmem_be    = alu_result_m_q[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{write_data_m_q[15:0]}};
      end
      2'b10:   dmem_be = 4'b1111;
      default: dmem_be = 4'b0000;
    endcase
    if (!dmem_we) dmem_be = 4'b0000;
  end

  load_extend u_load_extend (
    .funct3_i (funct3_w_q),
    .addr_i   (alu_result_w_q[1:0]),
    .rdata_i  (rdata_w_q),
    .data_o   (load_data)
  );

  always_comb begin
    validW    = valid_w_q;
    RegWriteW = reg_write_w_q & valid_w_q;
    rdW       = rd_w_q;
    instret   = instret_q;
    case (result_src_w_q)
      RES_MEM: resultW = load_data;
      RES_PC4: resultW = pc_plus4_w_q;
      default: resultW = alu_result_w_q;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Directed self-checking bench for mem_wb_pipeline with hand-computed expectations.
module tb_mem_wb_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallM, flushM, validE, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] alu_resultE, write_dataE, pc_plus4E, dmem_rdata;
  logic        validM, RegWriteM, dmem_we, validW, RegWriteW;
  logic [4:0]  rdM, rdW;
  logic [31:0] alu_resultM, dmem_addr, dmem_wdata, resultW;
  logic [3:0]  dmem_be;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipeline #(.XLEN(32), .CNT_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .stallM      (stallM),
    .flushM      (flushM),
    .validE      (validE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .funct3E     (funct3E),
    .rdE         (rdE),
    .alu_resultE (alu_resultE),
    .write_dataE (write_dataE),
    .pc_plus4E   (pc_plus4E),
    .dmem_rdata  (dmem_rdata),
    .validM      (validM),
    .RegWriteM   (RegWriteM),
    .rdM         (rdM),
    .alu_resultM (alu_resultM),
    .dmem_addr   (dmem_addr),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .validW      (validW),
    .RegWriteW   (RegWriteW),
    .rdW         (rdW),
    .resultW     (resultW),
    .instret     (instret)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
    validE = v; RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; funct3E = f3;
    rdE = rd; alu_resultE = alu; write_dataE = wd; pc_plus4E = pc4;
  endtask

  task automatic bubble_e();
    drive_e(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  logic [2:0]  ld_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] ld_addr [5] = '{32'h103, 32'h100, 32'h102, 32'h100, 32'h100};
  logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_7F82,
                               32'h80F1_7F82};

  initial begin
    reset = 1'b1; stallM = 1'b0; flushM = 1'b0; dmem_rdata = 32'h80F1_7F82;
    bubble_e();
    step();
    check_eq("rst_validM", validM, 0);
    check_eq("rst_validW", validW, 0);
    check_eq("rst_dmem_we", dmem_we, 0);
    check_eq("rst_dmem_be", dmem_be, 0);
    check_eq("rst_resultW", resultW, 0);
    check_eq("rst_instret", instret, 0);
    reset = 1'b0;

    // Back-to-back ALU op
    drive_e(1, 1, 0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0);
    step();
    check_eq("alu_validM", validM, 1);
    check_eq("alu_rdM", rdM, 5);
    check_eq("alu_RegWriteM", RegWriteM, 1);
    check_eq("alu_resultM", alu_resultM, 32'h1234);
    bubble_e();
    step();
    check_eq("alu_rdW", rdW, 5);
    check_eq("alu_RegWriteW", RegWriteW, 1);
    check_eq("alu_resultW", resultW, 32'h1234);
    check_eq("alu_instret_pre", instret, 0);
    step();
    check_eq("alu_instret", instret, 1);

    // Loads
    for (int i = 0; i < 5; i++) begin
      drive_e(1, 1, 0, 2'b01, ld_f3[i], 5'd10, ld_addr[i], 32'h0, 32'h0);
      step();
      check_eq("ld_dmem_addr", dmem_addr, ld_addr[i]);
      check_eq("ld_dmem_we", dmem_we, 0);
      bubble_e();
      step();
      check_eq($sformatf("ld_resultW_%0d", i), resultW, ld_exp[i]);
    end
    step();
    check_eq("ld_instret", instret, 6);

    // Stores
    drive_e(1, 0, 1, 2'b00, 3'b000, 5'd0, 32'h2, 32'hAABB_CCDD, 32'h0);
    step();
    check_eq("sb_we", dmem_we, 1);
    check_eq("sb_be", dmem_be, 4'b0100);
    check_eq("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
    drive_e(1, 0, 1, 2'b00, 3'b001, 5'd0, 32'h2, 32'hAABB_CCDD, 32'h0);
    step();
    check_eq("sh_be", dmem_be, 4'b1100);
    check_eq("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
    drive_e(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h0, 32'hAABB_CCDD, 32'h0);
    step();
    check_eq("sw_be", dmem_be, 4'b1111);
    check_eq("sw_wdata", dmem_wdata, 32'hAABB_CCDD);
    drive_e(0, 0, 1, 2'b00, 3'b010, 5'd0, 32'h0, 32'hAABB_CCDD, 32'h0);
    step();
    check_eq("bub_we", dmem_we, 0);
    check_eq("bub_be", dmem_be, 4'b0000);
    bubble_e();
    step();
    step();
    check_eq("st_instret", instret, 9);

    // Stall with a store in M, JAL waiting in E
    drive_e(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h40, 32'h1122_3344, 32'h0);
    step();
    drive_e(1, 1, 0, 2'b10, 3'b000, 5'd1, 32'h204, 32'h0, 32'h208);
    stallM = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stl_we", dmem_we, 1);
      check_eq("stl_be", dmem_be, 4'b1111);
      check_eq("stl_addrM", alu_resultM, 32'h40);
      check_eq("stl_validW", validW, 0);
      check_eq("stl_RegWriteW", RegWriteW, 0);
      check_eq("stl_instret", instret, 9);
    end
    stallM = 1'b0;
    step();
    check_eq("jal_rdM", rdM, 1);
    check_eq("jal_validW_store", validW, 1);
    bubble_e();
    step();
    check_eq("jal_resultW", resultW, 32'h208);
    check_eq("jal_rdW", rdW, 1);
    check_eq("jal_RegWriteW", RegWriteW, 1);
    check_eq("jal_instret", instret, 10);

    // Flush beats stall
    drive_e(1, 1, 0, 2'b00, 3'b000, 5'd7, 32'h55, 32'h0, 32'h0);
    flushM = 1'b1; stallM = 1'b1;
    step();
    check_eq("fl_validM", validM, 0);
    check_eq("fl_RegWriteM", RegWriteM, 0);
    flushM = 1'b0; stallM = 1'b0;
    bubble_e();
    step();
    check_eq("fl_validW", validW, 0);
    check_eq("fl_instret", instret, 11);

    // Async reset mid-stall
    drive_e(1, 1, 0, 2'b00, 3'b000, 5'd3, 32'h33, 32'h0, 32'h0);
    step();
    drive_e(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h80, 32'h5555_AAAA, 32'h0);
    step();
    stallM = 1'b1;
    #1;
    check_eq("ar_pre_we", dmem_we, 1);
    check_eq("ar_pre_validW", validW, 1);
    reset = 1'b1;
    #1;
    check_eq("ar_validM", validM, 0);
    check_eq("ar_validW", validW, 0);
    check_eq("ar_we", dmem_we, 0);
    check_eq("ar_instret", instret, 0);
    check_eq("ar_resultW", resultW, 0);
    #1;
    reset = 1'b0; stallM = 1'b0;
    drive_e(1, 1, 0, 2'b00, 3'b000, 5'd9, 32'h99, 32'h0, 32'h0);
    step();
    check_eq("post_rdM", rdM, 9);
    check_eq("post_validM", validM, 1);
    bubble_e();
    step();
    check_eq("post_rdW", rdW, 9);
    check_eq("post_resultW", resultW, 32'h99);
    step();
    check_eq("post_instret", instret, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipeline.md
Name: mem_wb_pipeline

Overview:
- EX/MEM and MEM/WB pipeline registers of the rv32i 5-stage core, with store formatting in M and load extraction/extension plus result selection in W.
- Produces rdM, RegWriteM, alu_resultM, rdW, RegWriteW and resultW, which the EX-stage forwarding logic consumes.
- Drives the data-memory port and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stallM  in  1  memory wait: hold EX/MEM, insert bubble into MEM/WB.
- flushM  in  1  replace the instruction entering EX/MEM with a bubble at the next edge.
- validE  in  1  EX slot holds a real instruction.
- RegWriteE  in  1  EX instruction writes rd.
- MemWriteE  in  1  EX instruction is a store.
- ResultSrcE  in  2  result source: 00 ALU, 01 load, 10 pc+4, 11 reserved (treated as ALU).
- funct3E  in  3  load/store size and sign.
- rdE  in  5  destination register.
- alu_resultE  in  32  ALU result or effective address.
- write_dataE  in  32  forwarded rs2 store data.
- pc_plus4E  in  32  link value.
- dmem_rdata  in  32  combinational read data for dmem_addr.
- validM  out  1  M slot valid.
- RegWriteM  out  1  RegWrite of M slot, gated by validM.
- rdM  out  5  M destination register.
- alu_resultM  out  32  M ALU result.
- dmem_addr  out  32  equals alu_resultM.
- dmem_we  out  1  MemWriteM & validM.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned store data.
- validW  out  1  W slot valid.
- RegWriteW  out  1  RegWrite of W slot, gated by validW.
- rdW  out  5  W destination register.
- resultW  out  32  writeback value.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- Reset (asynchronous, immediate): all valid, RegWrite and MemWrite flags are 0; rd, data, funct3 and ResultSrc fields are 0; instret = 0.
  - Outputs during reset: dmem_we = 0, dmem_be = 0, resultW = 0.
  - Reset mid-stall discards the held instruction.
- EX/MEM register, next-edge update, in priority order:
  - flushM = 1: load a bubble (valid = 0, all flags 0). Flush wins over a simultaneous stall.
  - else stallM = 1: hold.
  - else: capture the E fields. validM = validE; flags are AND-ed with validE on capture.
- MEM/WB register, next-edge update:
  - stallM = 1: load a bubble (validW = 0, RegWriteW = 0).
  - else: capture validM, RegWriteM, rdM, ResultSrcM, funct3M, alu_resultM[1:0], alu_resultM, pc_plus4M and the raw dmem_rdata.
- Latency: an E instruction appears in M after 1 edge and in W after 2 edges, with no stalls.
- Store formatting (combinational in M), by funct3M[1:0]:
  - 00 SB: dmem_be = 1 << addr[1:0]; data byte replicated to all 4 lanes.
  - 01 SH: dmem_be = addr[1] ? 1100 : 0011; data halfword replicated to both halves.
  - 10 SW: dmem_be = 1111.
  - 11: dmem_be = 0000 (no write).
  - dmem_be = 0000 whenever dmem_we = 0.
  - No misalignment trap: SH ignores addr[0]; SW ignores addr[1:0].
- Load extraction (combinational in W, using the registered addr[1:0]):
  - LB: byte lane addr[1:0], sign-extended.
  - LH: half lane addr[1], sign-extended.
  - LW: full word.
  - LBU, LHU: as LB, LH, zero-extended.
  - Any other funct3: full word.
- resultW by ResultSrcW:
  - 00 or 11: alu_resultW.
  - 01: extracted load data.
  - 10: pc_plus4W.
- A stalled store keeps dmem_we asserted on every stall cycle (wait-state memory).
- instret increments by 1 on each edge where validW = 1 before the edge. Bubbles do not count. Wraps modulo 2^CNT_W.
- rd = 0 is passed through unchanged; x0 filtering stays with the consumers.

Decomposition:
- Shared package rv32i_pkg holds:
  - ResultSrc encodings RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10.
  - funct3 load/store constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One natural sub-module: load_extend (funct3, addr[1:0], rdata -> 32-bit extended value), a purely combinational unit reused in W.

Test Plan:
- Back-to-back ALU ops: E gives rd = 5, RegWrite = 1, ResultSrc = 00, alu = 0x1234 -> next cycle rdM = 5, RegWriteM = 1, alu_resultM = 0x1234; following cycle rdW = 5, resultW = 0x1234; instret = 1 one edge later.
- Loads, dmem_rdata = 0x80F1_7F82:
  - LB addr 0x103 -> resultW = 0xFFFF_FF80.
  - LBU addr 0x100 -> 0x0000_0082.
  - LH addr 0x102 -> 0xFFFF_80F1.
  - LHU addr 0x100 -> 0x0000_7F82.
  - LW -> 0x80F1_7F82.
- Stores, write_data = 0xAABB_CCDD:
  - SB addr 0x2 -> be = 0100, wdata = 0xDDDD_DDDD.
  - SH addr 0x2 -> be = 1100, wdata = 0xCCDD_CCDD.
  - SW -> be = 1111.
  - Bubble store (validE = 0) -> dmem_we = 0, be = 0000.
- stallM held 2 cycles with a store in M -> dmem_we stays 1; M fields frozen; W shows 2 bubbles (RegWriteW = 0) and instret does not increment; JAL in E then completes with resultW = pc_plus4.
- flushM and stallM together on a valid RegWrite instruction -> after the edge validM = 0, RegWriteM = 0; after the next edge validW = 0.
- Reset asserted asynchronously mid-stall -> validM, validW, dmem_we and instret go 0 immediately, without a clock edge; after release the first E instruction flows normally.
